decoder_nto2n_seq: RTL and testbench

- Parametrised, registered N-to-2^N one-hot decoder.
- Successor to the fixed 3:8 combinational decoder.
- Adds:
  - enable,
  - valid/ready load handshake,
  - automatic one-hot scan sequencer (up/down) with programmable dwell,
  - hold mode and wrap reporting.
- Drives row/channel selects, LED/mux scanning and strobe generation.

---
 rtl/decoder_nto2n_seq_pkg.sv | 11 +
 rtl/decoder_nto2n_seq_onehot_dec.sv | 12 +
 rtl/decoder_nto2n_seq.sv | 106 ++++++++++
 tb/tb_decoder_nto2n_seq.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/decoder_nto2n_seq_pkg.sv
// Shared definitions for the sequenced N-to-2^N decoder: mode encoding and width.
package decoder_pkg;
  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_DIRECT  = 2'b00,
    MODE_SCAN_UP = 2'b01,
    MODE_SCAN_DN = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_e;
endpackage

// File: rtl/decoder_nto2n_seq_onehot_dec.sv
// Purely combinational N_IN -> 2**N_IN one-hot decoder.
module onehot_dec #(
  parameter int N_IN = 3
) (
  input  logic [N_IN-1:0]      code_i,
  output logic [2**N_IN-1:0]   onehot_o
);
  always_comb begin
    onehot_o         = '0;
    onehot_o[code_i] = 1'b1;
  end
endmodule

// File: rtl/decoder_nto2n_seq.sv
// Registered one-hot decoder with direct load, up/down scan sequencer with
// programmable dwell, hold mode and wrap pulse.
module decoder_nto2n_seq
  import decoder_pkg::*;
#(
  parameter int N_IN    = 3,
  parameter int DWELL_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [MODE_W-1:0]    mode,
  input  logic                 in_valid,
  input  logic [N_IN-1:0]      in,
  output logic                 in_ready,
  input  logic [DWELL_W-1:0]   dwell,
  output logic [2**N_IN-1:0]   out,
  output logic                 out_valid,
  output logic [N_IN-1:0]      code,
  output logic                 wrap
);
  localparam int OUT_W = 2**N_IN;

  mode_e              mode_cur, mode_q;
  logic [N_IN-1:0]    code_q, code_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d, cnt_eff;
  logic [OUT_W-1:0]   out_q, out_d, dec;
  logic               out_valid_q, out_valid_d;
  logic               wrap_q, wrap_d;
  logic               mode_chg, step_due;

  assign mode_cur = mode_e'(mode);
  assign in_ready = rst_n && en && (mode_cur == MODE_DIRECT);

  always_comb begin
    mode_chg    = (mode_cur != mode_q);
    // Any mode change restarts dwell timing from zero on this very edge.
    cnt_eff     = mode_chg ? '0 : cnt_q;
    step_due    = (cnt_eff >= dwell);
    code_d      = code_q;
    cnt_d       = cnt_q;
    wrap_d      = 1'b0;
    out_valid_d = 1'b0;
    if (!en) begin
      cnt_d = '0;
    end else begin
      out_valid_d = 1'b1;
      case (mode_cur)
        MODE_DIRECT: begin
          cnt_d = '0;
          if (in_valid) code_d = in;
        end
        MODE_SCAN_UP: begin
          if (step_due) begin
            cnt_d  = '0;
            code_d = code_q + 1'b1;
            wrap_d = (code_q == {N_IN{1'b1}});
          end else begin
            cnt_d = cnt_eff + 1'b1;
          end
        end
        MODE_SCAN_DN: begin
          if (step_due) begin
            cnt_d  = '0;
            code_d = code_q - 1'b1;
            wrap_d = (code_q == '0);
          end else begin
            cnt_d = cnt_eff + 1'b1;
          end
        end
        MODE_HOLD: cnt_d = cnt_eff;
        default: ;
      endcase
    end
  end

  onehot_dec #(.N_IN(N_IN)) u_dec (
    .code_i   (code_d),
    .onehot_o (dec)
  );

  assign out_d = out_valid_d ? dec : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_DIRECT;
      code_q      <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      mode_q      <= mode_cur;
      code_q      <= code_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      wrap_q      <= wrap_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign code      = code_q;
  assign wrap      = wrap_q;
endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Directed bench for decoder_nto2n_seq (N_IN=3, DWELL_W=8).
module tb_decoder_nto2n_seq;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       in_valid;
  logic [2:0] in_r;
  logic       in_ready;
  logic [7:0] dwell;
  logic [7:0] out;
  logic       out_valid;
  logic [2:0] code;
  logic       wrap;

  int n_run  = 0;
  int n_fail = 0;

  decoder_nto2n_seq #(.N_IN(3), .DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
    .in(in_r), .in_ready(in_ready), .dwell(dwell), .out(out),
    .out_valid(out_valid), .code(code), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [2:0] ec, input logic ew);
    chk({tag, ".code"}, 32'(code), 32'(ec));
    chk({tag, ".out"}, 32'(out), 32'(8'h01 << ec));
    chk({tag, ".wrap"}, 32'(wrap), 32'(ew));
  endtask

  task automatic load(input logic [2:0] v);
    mode = 2'b00; in_r = v; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  logic [2:0] up_code [9] = '{3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd1};
  logic       up_wrap [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [2:0] dn_code [3] = '{3'd0, 3'd7, 3'd6};
  logic       dn_wrap [3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    rst_n = 1'b0; en = 1'b1; mode = 2'b00; in_valid = 1'b0; in_r = '0; dwell = '0;
    #3;
    chk("rst.out", 32'(out), 0);
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.code", 32'(code), 0);
    chk("rst.wrap", 32'(wrap), 0);
    chk("rst.in_ready", 32'(in_ready), 0);
    #9 rst_n = 1'b1;

    // DIRECT sweep
    for (int i = 0; i < 8; i++) begin
      in_r = 3'(i); in_valid = 1'b1;
      #1 chk("dir.in_ready", 32'(in_ready), 1);
      tick();
      chk("dir.out", 32'(out), 32'(8'h01 << i));
      chk("dir.code", 32'(code), 32'(i));
      chk("dir.out_valid", 32'(out_valid), 1);
    end
    in_valid = 1'b0;
    tick();
    chk("dir.hold", 32'(out), 32'h80);

    // SCAN_UP wrap from code 6, dwell 2
    load(3'd6);
    dwell = 8'd2; mode = 2'b01;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk_state("up", up_code[i], up_wrap[i]);
    end

    // SCAN_DN wrap from code 1, dwell 0
    load(3'd1);
    chk("dn.start", 32'(out), 32'h02);
    dwell = 8'd0; mode = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_state("dn", dn_code[i], dn_wrap[i]);
    end

    // HOLD, then return to scan with a short dwell
    load(3'd2);
    dwell = 8'd200; mode = 2'b01;
    repeat (50) tick();
    chk("hold.pre", 32'(code), 2);
    mode = 2'b11; in_valid = 1'b1; in_r = 3'd7;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_state("hold", 3'd2, 1'b0);
    end
    in_valid = 1'b0;
    mode = 2'b01; dwell = 8'd3;
    repeat (3) tick();
    chk("hold.resume3", 32'(code), 2);
    tick();
    chk_state("hold.resume4", 3'd3, 1'b0);

    // Dwell shrink below current count forces a step
    dwell = 8'd200;
    repeat (50) tick();
    chk("shrink.pre", 32'(code), 3);
    dwell = 8'd3;
    tick();
    chk_state("shrink", 3'd4, 1'b0);

    // Enable gating
    load(3'd5);
    en = 1'b0; in_valid = 1'b1; in_r = 3'd2;
    #1 chk("en0.in_ready", 32'(in_ready), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("en0.out", 32'(out), 0);
      chk("en0.out_valid", 32'(out_valid), 0);
    end
    en = 1'b1; in_valid = 1'b0;
    #1 chk("en1.in_ready", 32'(in_ready), 1);
    tick();
    chk_state("en1", 3'd5, 1'b0);
    chk("en1.out_valid", 32'(out_valid), 1);

    // Reset mid-scan, asserted between edges
    mode = 2'b01; dwell = 8'd0;
    tick();
    tick();
    chk("mid.code", 32'(code), 7);
    #2 rst_n = 1'b0;
    #1;
    chk("mid.rst.out", 32'(out), 0);
    chk("mid.rst.code", 32'(code), 0);
    chk("mid.rst.out_valid", 32'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  // Output invariant sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n)
      chk("invariant", 32'(out), out_valid ? 32'(8'h01 << code) : 32'd0);
  end
endmodule
